// File: rtl/dht_pkg.sv
// dht_pkg: shared FSM states, error codes and timing helper for the DHT sensor reader.
package dht_pkg;
  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, FAIL, HOLDOFF
  } state_t;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_NO_RESP = 3'd1;
  localparam logic [2:0] ERR_SYNC    = 3'd2;
  localparam logic [2:0] ERR_BIT     = 3'd3;
  localparam logic [2:0] ERR_CSUM    = 3'd4;
  localparam int unsigned DHT22_START_US = 1_000;
  // The synchroniser still shows our own start pulse for a couple of cycles after release.
  localparam int unsigned SETTLE_CYCLES = 3;
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for the asynchronous sensor line; resets to the idle-high level.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clock) begin
    if (reset) {q_o, meta_q} <= 2'b11;
    else       {q_o, meta_q} <= {meta_q, d_i};
  end
endmodule

// File: rtl/dht_sensor_reader.sv
// dht_sensor_reader: DHT11/DHT22 single-wire reader; start pulse, response sync,
// 40-bit frame capture, checksum verification and a re-read holdoff.
module dht_sensor_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned START_LOW_US    = 18_000,
  parameter int unsigned RESP_TIMEOUT_US = 100,
  parameter int unsigned BIT_THRESH_US   = 40,
  parameter int unsigned BIT_TIMEOUT_US  = 100,
  parameter int unsigned HOLDOFF_MS      = 1_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_dht22,
  input  logic        dq_in,
  output logic        dq_oe,
  output logic        busy,
  output logic        data_valid,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [15:0] hum_raw,
  output logic [15:0] temp_raw
);
  localparam int unsigned T_START11 = us_to_cycles(CLK_HZ, START_LOW_US);
  localparam int unsigned T_START22 = us_to_cycles(CLK_HZ, DHT22_START_US);
  localparam int unsigned T_RESP    = us_to_cycles(CLK_HZ, RESP_TIMEOUT_US);
  localparam int unsigned T_THRESH  = us_to_cycles(CLK_HZ, BIT_THRESH_US);
  localparam int unsigned T_BIT     = us_to_cycles(CLK_HZ, BIT_TIMEOUT_US);
  localparam int unsigned T_HOLD    = us_to_cycles(CLK_HZ, HOLDOFF_MS * 1_000);
  localparam int unsigned T_SMAX    = T_START11 > T_START22 ? T_START11 : T_START22;
  localparam int unsigned T_MAX     = T_SMAX > T_HOLD ? T_SMAX : T_HOLD;
  localparam int unsigned CW        = $clog2(T_MAX + 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q, limit;
  logic [5:0]    idx_q;
  logic [39:0]   shift_q;
  logic [7:0]    csum;
  logic [2:0]    err_q;
  logic [15:0]   hum_q, temp_q;
  logic          mode_q, dq_oe_q, busy_q, valid_q, error_q, line, last;

  sync_2ff u_sync (.clock(clock), .reset(reset), .d_i(dq_in), .q_o(line));

  assign limit = (state_q == START_LOW) ? (mode_q ? CW'(T_START22) : CW'(T_START11)) :
                 (state_q == HOLDOFF) ? CW'(T_HOLD) :
                 (state_q inside {RELEASE, RESP_LOW, RESP_HIGH}) ? CW'(T_RESP) : CW'(T_BIT);
  assign last  = cnt_q == limit - 1'b1;
  assign csum  = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      mode_q  <= 1'b0;
      dq_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
      hum_q   <= '0;
      temp_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            state_q <= START_LOW;
            busy_q  <= 1'b1;
            mode_q  <= mode_dht22;
            dq_oe_q <= 1'b1;
            err_q   <= ERR_NONE;
            idx_q   <= '0;
          end
        end
        START_LOW: if (last) begin
          state_q <= RELEASE;
          cnt_q   <= '0;
          dq_oe_q <= 1'b0;
        end
        RELEASE:
          if (!line && cnt_q >= CW'(SETTLE_CYCLES)) begin state_q <= RESP_LOW; cnt_q <= '0; end
          else if (last) begin state_q <= FAIL; cnt_q <= '0; err_q <= ERR_NO_RESP; end
        RESP_LOW:
          if (line) begin state_q <= RESP_HIGH; cnt_q <= '0; end
          else if (last) begin state_q <= FAIL; cnt_q <= '0; err_q <= ERR_SYNC; end
        RESP_HIGH:
          if (!line) begin state_q <= BIT_LOW; cnt_q <= '0; end
          else if (last) begin state_q <= FAIL; cnt_q <= '0; err_q <= ERR_SYNC; end
        BIT_LOW:
          if (line) begin state_q <= BIT_HIGH; cnt_q <= '0; end
          else if (last) begin state_q <= FAIL; cnt_q <= '0; err_q <= ERR_BIT; end
        // High time seen is cnt_q+1 cycles, so "longer than threshold" is cnt_q >= threshold.
        BIT_HIGH:
          if (!line) begin
            shift_q <= {shift_q[38:0], cnt_q >= CW'(T_THRESH)};
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            state_q <= (idx_q == 6'd39) ? CHECK : BIT_LOW;
          end else if (last) begin state_q <= FAIL; cnt_q <= '0; err_q <= ERR_BIT; end
        CHECK: begin
          cnt_q <= '0;
          if (csum == shift_q[7:0]) begin
            state_q <= HOLDOFF;
            valid_q <= 1'b1;
            hum_q   <= shift_q[39:24];
            temp_q  <= shift_q[23:8];
            err_q   <= ERR_NONE;
          end else begin
            state_q <= FAIL;
            err_q   <= ERR_CSUM;
          end
        end
        FAIL: begin
          state_q <= HOLDOFF;
          cnt_q   <= '0;
          error_q <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        HOLDOFF: if (last) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dq_oe      = dq_oe_q;
  assign busy       = busy_q;
  assign data_valid = valid_q;
  assign error      = error_q;
  assign err_code   = err_q;
  assign hum_raw    = hum_q;
  assign temp_raw   = temp_q;
endmodule

// File: tb/tb_dht_sensor_reader.sv
// tb_dht_sensor_reader: directed scenarios against a behavioural DHT sensor at 1 MHz (1 cycle = 1 us).
module tb_dht_sensor_reader;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, mode_dht22 = 1'b0, sens = 1'b1;
  logic dq_in, dq_oe, busy, data_valid, error;
  logic [2:0] err_code;
  logic [15:0] hum_raw, temp_raw;
  int tests_run = 0, fails = 0;
  int dv_cnt = 0, err_cnt = 0, both_cnt = 0;

  localparam logic [40-1:0] FRAME11 = 40'h37_00_18_00_4F;
  localparam logic [40-1:0] FRAME11_BAD = 40'h37_00_18_00_50;
  localparam logic [40-1:0] FRAME22 = 40'h02_8C_80_65_73;

  assign dq_in = sens & ~dq_oe;
  always #5 clock = ~clock;

  dht_sensor_reader #(.CLK_HZ(1_000_000), .HOLDOFF_MS(2)) dut (
    .clock(clock), .reset(reset), .start(start), .mode_dht22(mode_dht22), .dq_in(dq_in),
    .dq_oe(dq_oe), .busy(busy), .data_valid(data_valid), .error(error), .err_code(err_code),
    .hum_raw(hum_raw), .temp_raw(temp_raw)
  );

  always @(negedge clock) begin
    if (data_valid) dv_cnt++;
    if (error) err_cnt++;
    if (data_valid && error) both_cnt++;
  end

  task automatic hold(input logic v, input int n);
    sens = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issues a start, measures the host low pulse, then plays the sensor side (nbits < 0: silent).
  task automatic run_txn(input logic [39:0] frame, input int nbits, input logic m, output int lowc);
    @(posedge clock); #1 start = 1'b1; mode_dht22 = m;
    @(posedge clock); #1 start = 1'b0;
    lowc = 0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clock);
      if (!dq_oe) break;
      lowc++;
    end
    if (nbits < 0) return;
    @(posedge clock); #1;
    hold(1'b1, 20); hold(1'b0, 80); hold(1'b1, 80);
    for (int b = 0; b < nbits; b++) begin
      hold(1'b0, 50);
      hold(1'b1, frame[39-b] ? 70 : 26);
    end
    if (nbits == 40) hold(1'b0, 50);
    sens = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      cyc++;
      if (!busy) break;
    end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_timeout busy got %b expected 0", busy); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run += 7;
    if (dq_oe !== 1'b0) begin fails++; $display("FAIL rst_dq_oe got %b expected 0", dq_oe); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b expected 0", busy); end
    if (data_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b expected 0", data_valid); end
    if (error !== 1'b0) begin fails++; $display("FAIL rst_error got %b expected 0", error); end
    if (err_code !== 3'd0) begin fails++; $display("FAIL rst_err_code got %0d expected 0", err_code); end
    if (hum_raw !== 16'h0) begin fails++; $display("FAIL rst_hum got %h expected 0000", hum_raw); end
    if (temp_raw !== 16'h0) begin fails++; $display("FAIL rst_temp got %h expected 0000", temp_raw); end
    #1 reset = 1'b0;
  endtask

  task automatic test_good_dht11;
    int lowc, m, dv0, e0;
    dv0 = dv_cnt; e0 = err_cnt;
    run_txn(FRAME11, 40, 1'b0, lowc);
    tests_run += 2;
    if (lowc !== 18000) begin fails++; $display("FAIL good_start_low got %0d expected 18000", lowc); end
    if (busy !== 1'b1) begin fails++; $display("FAIL good_busy_holdoff got %b expected 1", busy); end
    wait_idle(m);
    tests_run += 5;
    if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL good_valid_pulses got %0d expected 1", dv_cnt - dv0); end
    if (err_cnt - e0 !== 0) begin fails++; $display("FAIL good_error_pulses got %0d expected 0", err_cnt - e0); end
    if (hum_raw !== 16'h3700) begin fails++; $display("FAIL good_hum got %h expected 3700", hum_raw); end
    if (temp_raw !== 16'h1800) begin fails++; $display("FAIL good_temp got %h expected 1800", temp_raw); end
    if (err_code !== 3'd0) begin fails++; $display("FAIL good_err_code got %0d expected 0", err_code); end
  endtask

  task automatic test_bad_checksum;
    int lowc, m, dv0, e0;
    dv0 = dv_cnt; e0 = err_cnt;
    run_txn(FRAME11_BAD, 40, 1'b0, lowc);
    wait_idle(m);
    tests_run += 5;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL csum_error_pulses got %0d expected 1", err_cnt - e0); end
    if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL csum_valid_pulses got %0d expected 0", dv_cnt - dv0); end
    if (err_code !== 3'd4) begin fails++; $display("FAIL csum_err_code got %0d expected 4", err_code); end
    if (hum_raw !== 16'h3700) begin fails++; $display("FAIL csum_hum_kept got %h expected 3700", hum_raw); end
    if (temp_raw !== 16'h1800) begin fails++; $display("FAIL csum_temp_kept got %h expected 1800", temp_raw); end
  endtask

  task automatic test_no_response;
    int lowc, n, m;
    run_txn('0, -1, 1'b1, lowc);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      n++;
      if (error) break;
    end
    tests_run += 4;
    if (lowc !== 1000) begin fails++; $display("FAIL silent_start_low got %0d expected 1000", lowc); end
    if (n !== 101) begin fails++; $display("FAIL silent_error_delay got %0d expected 101", n); end
    if (err_code !== 3'd1) begin fails++; $display("FAIL silent_err_code got %0d expected 1", err_code); end
    if (busy !== 1'b1) begin fails++; $display("FAIL silent_busy got %b expected 1", busy); end
    wait_idle(m);
    tests_run++;
    if (m !== 2000) begin fails++; $display("FAIL silent_holdoff got %0d expected 2000", m); end
  endtask

  task automatic test_bit_timeout;
    int lowc, m, e0;
    e0 = err_cnt;
    run_txn(FRAME22, 20, 1'b1, lowc);
    wait_idle(m);
    tests_run += 3;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL bitto_error_pulses got %0d expected 1", err_cnt - e0); end
    if (err_code !== 3'd3) begin fails++; $display("FAIL bitto_err_code got %0d expected 3", err_code); end
    if (hum_raw !== 16'h3700) begin fails++; $display("FAIL bitto_hum_kept got %h expected 3700", hum_raw); end
  endtask

  task automatic test_back_to_back;
    int lowc, m, dv0, act;
    dv0 = dv_cnt;
    run_txn(FRAME22, 40, 1'b1, lowc);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
    wait_idle(m);
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (dq_oe || busy) act++;
    end
    tests_run += 6;
    if (lowc !== 1000) begin fails++; $display("FAIL dht22_start_low got %0d expected 1000", lowc); end
    if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL dht22_valid_pulses got %0d expected 1", dv_cnt - dv0); end
    if (hum_raw !== 16'h028C) begin fails++; $display("FAIL dht22_hum got %h expected 028c", hum_raw); end
    if (temp_raw !== 16'h8065) begin fails++; $display("FAIL dht22_temp got %h expected 8065", temp_raw); end
    if (err_code !== 3'd0) begin fails++; $display("FAIL dht22_err_code got %0d expected 0", err_code); end
    if (act !== 0) begin fails++; $display("FAIL ignored_start_activity got %0d expected 0", act); end
  endtask

  task automatic test_reset_mid;
    int lowc, dv0, e0;
    @(posedge clock); #1 start = 1'b1; mode_dht22 = 1'b0;
    @(posedge clock); #1 start = 1'b0;
    repeat (100) @(negedge clock);
    tests_run++;
    if (dq_oe !== 1'b1) begin fails++; $display("FAIL midrst_pre_dq_oe got %b expected 1", dq_oe); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    tests_run++;
    if (dq_oe !== 1'b0) begin fails++; $display("FAIL midrst_start_dq_oe got %b expected 0", dq_oe); end
    #1 reset = 1'b0;
    dv0 = dv_cnt; e0 = err_cnt;
    run_txn(FRAME22, 10, 1'b1, lowc);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    tests_run += 3;
    if (dq_oe !== 1'b0) begin fails++; $display("FAIL midrst_dq_oe got %b expected 0", dq_oe); end
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b expected 0", busy); end
    if (hum_raw !== 16'h0) begin fails++; $display("FAIL midrst_hum got %h expected 0000", hum_raw); end
    repeat (5) @(negedge clock);
    #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    tests_run += 2;
    if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL midrst_valid got %0d expected 0", dv_cnt - dv0); end
    if (err_cnt - e0 !== 0) begin fails++; $display("FAIL midrst_error got %0d expected 0", err_cnt - e0); end
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL midrst_idle_accepts got %b expected 1", busy); end
  endtask

  initial begin
    test_reset;
    test_good_dht11;
    test_bad_checksum;
    test_no_response;
    test_bit_timeout;
    test_back_to_back;
    test_reset_mid;
    tests_run++;
    if (both_cnt !== 0) begin fails++; $display("FAIL valid_and_error_same_cycle got %0d expected 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
